stack_op_controller: RTL and testbench

//  Sequences stack operations (PUSH, POP, CALL, RET, LDSP) onto the 8-bit stack pointer
//  (SP_load_en / inr_SP / dcr_SP) and the 16-bit-word data memory port.

---
 rtl/stack_op_controller.sv | 182 ++++++++++++++++++
 tb/tb_stack_op_controller.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/stack_op_controller.sv
// rtl/stack_op_controller.sv - stack operation sequencer driving SP strobes and data memory port
// Optional range checking on PUSH/CALL/POP/RET is enabled by defining STACK_BOUNDS_CHECK_EN.
module stack_op_controller #(
    parameter logic [7:0] SP_TOP      = 8'hF0,
    parameter logic [7:0] SP_LIMIT_LO = 8'h80
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [2:0]  op_code,
    input  logic [15:0] op_data,
    input  logic [15:0] pc_ret,
    input  logic [7:0]  sp,
    output logic        SP_load_en,
    output logic [7:0]  SP_load,
    output logic        inr_SP,
    output logic        dcr_SP,
    output logic [7:0]  mem_addr,
    output logic        mem_we,
    output logic        mem_re,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    output logic        pc_load_en,
    output logic [15:0] pc_load,
    output logic [15:0] pop_data,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code
);

    typedef enum logic [2:0] {IDLE, DEC, WRITE, READ, CAPT, LOAD, FIN} state_t;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_PUSH = 3'b001;
    localparam logic [2:0] OP_POP  = 3'b010;
    localparam logic [2:0] OP_CALL = 3'b011;
    localparam logic [2:0] OP_RET  = 3'b100;
    localparam logic [2:0] OP_LDSP = 3'b101;

    localparam logic [1:0] EC_NONE  = 2'b00;
    localparam logic [1:0] EC_ILL   = 2'b01;
    localparam logic [1:0] EC_OVER  = 2'b10;
    localparam logic [1:0] EC_UNDER = 2'b11;

    state_t      state, next_state;
    logic [2:0]  op_q;
    logic [15:0] data_q;
    logic [15:0] ret_q;
    logic [1:0]  fin_code_q, fin_code_d;
    logic [15:0] pop_q;
    logic [1:0]  err_code_q;
    logic [1:0]  cur_code;
    logic        accept;
    logic        bound_en;
    logic        overflow, underflow;

`ifdef STACK_BOUNDS_CHECK_EN
    assign bound_en = 1'b1;
`else
    assign bound_en = 1'b0;
`endif

    // Range decisions use the SP value present at accept time.
    assign overflow  = bound_en && (sp <= SP_LIMIT_LO);
    assign underflow = bound_en && (sp >= SP_TOP);
    assign accept    = op_valid && (state == IDLE);

    always_comb begin
        next_state = state;
        fin_code_d = EC_NONE;
        case (state)
            IDLE: if (accept) begin
                case (op_code)
                    OP_NOP:  next_state = FIN;
                    OP_PUSH, OP_CALL: begin
                        next_state = overflow ? FIN : DEC;
                        fin_code_d = overflow ? EC_OVER : EC_NONE;
                    end
                    OP_POP, OP_RET: begin
                        next_state = underflow ? FIN : READ;
                        fin_code_d = underflow ? EC_UNDER : EC_NONE;
                    end
                    OP_LDSP: next_state = LOAD;
                    default: begin
                        next_state = FIN;
                        fin_code_d = EC_ILL;
                    end
                endcase
            end
            DEC:     next_state = WRITE;
            READ:    next_state = CAPT;
            WRITE, CAPT, LOAD, FIN: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            op_q       <= OP_NOP;
            data_q     <= 16'h0000;
            ret_q      <= 16'h0000;
            fin_code_q <= EC_NONE;
            pop_q      <= 16'h0000;
            err_code_q <= EC_NONE;
        end else begin
            state <= next_state;
            if (accept) begin
                op_q       <= op_code;
                data_q     <= op_data;
                ret_q      <= pc_ret;
                fin_code_q <= fin_code_d;
            end
            if (done)
                err_code_q <= cur_code;
            if (state == CAPT && op_q == OP_POP)
                pop_q <= mem_rdata;
        end
    end

    always_comb begin
        op_ready   = (state == IDLE);
        SP_load_en = 1'b0;
        SP_load    = 8'h00;
        inr_SP     = 1'b0;
        dcr_SP     = 1'b0;
        mem_addr   = 8'h00;
        mem_we     = 1'b0;
        mem_re     = 1'b0;
        mem_wdata  = 16'h0000;
        pc_load_en = 1'b0;
        pc_load    = 16'h0000;
        pop_data   = pop_q;
        done       = 1'b0;
        err        = 1'b0;
        cur_code   = EC_NONE;
        case (state)
            DEC: dcr_SP = 1'b1;
            WRITE: begin
                mem_addr = sp;
                mem_we   = 1'b1;
                done     = 1'b1;
                if (op_q == OP_CALL) begin
                    mem_wdata  = ret_q;
                    pc_load_en = 1'b1;
                    pc_load    = data_q;
                end else begin
                    mem_wdata = data_q;
                end
            end
            READ: begin
                mem_addr = sp;
                mem_re   = 1'b1;
            end
            CAPT: begin
                inr_SP = 1'b1;
                done   = 1'b1;
                if (op_q == OP_RET) begin
                    pc_load_en = 1'b1;
                    pc_load    = mem_rdata;
                end else begin
                    pop_data = mem_rdata;
                end
            end
            LOAD: begin
                SP_load_en = 1'b1;
                SP_load    = data_q[7:0];
                done       = 1'b1;
            end
            FIN: begin
                done     = 1'b1;
                cur_code = fin_code_q;
                err      = (fin_code_q != EC_NONE);
            end
            default: ;
        endcase
        // err_code tracks the completing op during done, otherwise holds the last result.
        err_code = done ? cur_code : err_code_q;
    end

endmodule

// File: tb/tb_stack_op_controller.sv
// tb/tb_stack_op_controller.sv - scoreboard bench for stack_op_controller
module tb_stack_op_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        op_valid;
    logic        op_ready;
    logic [2:0]  op_code;
    logic [15:0] op_data;
    logic [15:0] pc_ret;
    logic [7:0]  sp;
    logic        SP_load_en;
    logic [7:0]  SP_load;
    logic        inr_SP;
    logic        dcr_SP;
    logic [7:0]  mem_addr;
    logic        mem_we;
    logic        mem_re;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        pc_load_en;
    logic [15:0] pc_load;
    logic [15:0] pop_data;
    logic        done;
    logic        err;
    logic [1:0]  err_code;

    stack_op_controller dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
        .op_code(op_code), .op_data(op_data), .pc_ret(pc_ret), .sp(sp),
        .SP_load_en(SP_load_en), .SP_load(SP_load), .inr_SP(inr_SP), .dcr_SP(dcr_SP),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_re(mem_re), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .pc_load_en(pc_load_en), .pc_load(pc_load),
        .pop_data(pop_data), .done(done), .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        e_err;
        bit [1:0]  e_code;
        bit        e_we;
        bit [7:0]  e_addr;
        bit [15:0] e_wd;
        bit        e_pcl;
        bit [15:0] e_pc;
        bit        e_pop;
        bit [15:0] e_pv;
        bit        e_ld;
        bit [7:0]  e_lv;
        int        e_lat;
        int        e_str;
        bit [7:0]  e_sp;
        int        acc;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          strobe_cnt = 0;
    bit          sp_pend = 0;
    bit [7:0]    sp_exp;
    bit          we_seen = 0;
    logic [15:0] mem [256];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Environment: external SP register and synchronous-read data memory
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset) sp <= 8'hF0;
        else if (SP_load_en) sp <= SP_load;
        else if (inr_SP) sp <= sp + 8'd1;
        else if (dcr_SP) sp <= sp - 8'd1;
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr];
    end

    // Monitor: pops the scoreboard whenever the DUT signals done
    always @(negedge clk) begin
        if (reset) begin
            strobe_cnt = 0;
            sp_pend = 0;
        end else begin
            if ((int'(SP_load_en) + int'(inr_SP) + int'(dcr_SP)) > 1 || (mem_we && mem_re)) begin
                errors++;
                $display("FAIL strobe_exclusive: ld=%b inr=%b dcr=%b we=%b re=%b", SP_load_en, inr_SP, dcr_SP, mem_we, mem_re);
            end
            if (mem_we) we_seen = 1;
            strobe_cnt += int'(SP_load_en) + int'(inr_SP) + int'(dcr_SP) + int'(mem_we) + int'(mem_re) + int'(pc_load_en);
            if (sp_pend) begin
                chk("sp_after", sp, sp_exp);
                sp_pend = 0;
            end
            if (done) begin
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done: got done=1 expected no pending op");
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("latency", cyc - e.acc, e.e_lat);
                    chk("err", err, e.e_err);
                    chk("err_code", err_code, e.e_code);
                    chk("strobe_count", strobe_cnt, e.e_str);
                    chk("mem_we", mem_we, e.e_we);
                    chk("pc_load_en", pc_load_en, e.e_pcl);
                    if (e.e_we) begin
                        chk("mem_addr", mem_addr, e.e_addr);
                        chk("mem_wdata", mem_wdata, e.e_wd);
                    end
                    if (e.e_pcl) chk("pc_load", pc_load, e.e_pc);
                    if (e.e_pop) chk("pop_data", pop_data, e.e_pv);
                    if (e.e_ld)  chk("SP_load", SP_load, e.e_lv);
                    sp_exp  = e.e_sp;
                    sp_pend = 1;
                end
                strobe_cnt = 0;
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic [15:0] d, input logic [15:0] r,
                         input bit e_err, input bit [1:0] e_code,
                         input bit e_we, input bit [7:0] e_addr, input bit [15:0] e_wd,
                         input bit e_pcl, input bit [15:0] e_pc,
                         input bit e_pop, input bit [15:0] e_pv,
                         input bit e_ld, input bit [7:0] e_lv,
                         input int e_lat, input int e_str, input bit [7:0] e_sp);
        exp_t e;
        int   acc;
        chk("op_ready_idle", op_ready, 1'b1);
        op_valid = 1'b1;
        op_code  = op;
        op_data  = d;
        pc_ret   = r;
        acc      = cyc;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        op_code  = 3'b000;
        op_data  = 16'hDEAD;
        pc_ret   = 16'hBEEF;
        e = '{e_err, e_code, e_we, e_addr, e_wd, e_pcl, e_pc, e_pop, e_pv, e_ld, e_lv, e_lat, e_str, e_sp, acc};
        sb.push_back(e);
        for (int i = 0; i < 20; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done expected done within 20 cycles");
            sb.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        reset = 1'b1; op_valid = 1'b0; op_code = 3'b000; op_data = 16'h0; pc_ret = 16'h0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_op_ready", op_ready, 1'b1);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_err_code", err_code, 2'b00);
        chk("rst_strobes", {SP_load_en, inr_SP, dcr_SP, mem_we, mem_re, pc_load_en}, 6'b0);
        chk("rst_outputs", {mem_addr, SP_load, pop_data, pc_load, mem_wdata}, 56'h0);
        chk("rst_sp", sp, 8'hF0);

        // op, data, ret, err, code, we, addr, wdata, pcl, pc, pop, pv, ld, lv, lat, strobes, sp
        issue(3'b001, 16'h1234, 16'h0000, 0, 2'b00, 1, 8'hEF, 16'h1234, 0, 16'h0, 0, 16'h0, 0, 8'h0, 2, 2, 8'hEF);
        issue(3'b010, 16'h0000, 16'h0000, 0, 2'b00, 0, 8'h00, 16'h0000, 0, 16'h0, 1, 16'h1234, 0, 8'h0, 2, 2, 8'hF0);
        issue(3'b011, 16'h0100, 16'h0042, 0, 2'b00, 1, 8'hEF, 16'h0042, 1, 16'h0100, 0, 16'h0, 0, 8'h0, 2, 3, 8'hEF);
        issue(3'b100, 16'h0000, 16'h0000, 0, 2'b00, 0, 8'h00, 16'h0000, 1, 16'h0042, 0, 16'h0, 0, 8'h0, 2, 3, 8'hF0);
        chk("pop_data_held", pop_data, 16'h1234);
        issue(3'b000, 16'h0000, 16'h0000, 0, 2'b00, 0, 8'h00, 16'h0000, 0, 16'h0, 0, 16'h0, 0, 8'h0, 1, 0, 8'hF0);
        issue(3'b110, 16'h0000, 16'h0000, 1, 2'b01, 0, 8'h00, 16'h0000, 0, 16'h0, 0, 16'h0, 0, 8'h0, 1, 0, 8'hF0);
        issue(3'b111, 16'h5A5A, 16'h0000, 1, 2'b01, 0, 8'h00, 16'h0000, 0, 16'h0, 0, 16'h0, 0, 8'h0, 1, 0, 8'hF0);
        chk("err_code_held", err_code, 2'b01);
        chk("err_idle", err, 1'b0);

        issue(3'b101, 16'hAB81, 16'h0000, 0, 2'b00, 0, 8'h00, 16'h0000, 0, 16'h0, 0, 16'h0, 1, 8'h81, 1, 1, 8'h81);
        chk("err_code_cleared", err_code, 2'b00);
        issue(3'b001, 16'hAAAA, 16'h0000, 0, 2'b00, 1, 8'h80, 16'hAAAA, 0, 16'h0, 0, 16'h0, 0, 8'h0, 2, 2, 8'h80);
`ifdef STACK_BOUNDS_CHECK_EN
        issue(3'b001, 16'hBBBB, 16'h0000, 1, 2'b10, 0, 8'h00, 16'h0000, 0, 16'h0, 0, 16'h0, 0, 8'h0, 1, 0, 8'h80);
        issue(3'b101, 16'h00F0, 16'h0000, 0, 2'b00, 0, 8'h00, 16'h0000, 0, 16'h0, 0, 16'h0, 1, 8'hF0, 1, 1, 8'hF0);
        issue(3'b010, 16'h0000, 16'h0000, 1, 2'b11, 0, 8'h00, 16'h0000, 0, 16'h0, 0, 16'h0, 0, 8'h0, 1, 0, 8'hF0);
        issue(3'b101, 16'h0000, 16'h0000, 0, 2'b00, 0, 8'h00, 16'h0000, 0, 16'h0, 0, 16'h0, 1, 8'h00, 1, 1, 8'h00);
        issue(3'b001, 16'h5555, 16'h0000, 1, 2'b10, 0, 8'h00, 16'h0000, 0, 16'h0, 0, 16'h0, 0, 8'h0, 1, 0, 8'h00);
`else
        issue(3'b001, 16'hBBBB, 16'h0000, 0, 2'b00, 1, 8'h7F, 16'hBBBB, 0, 16'h0, 0, 16'h0, 0, 8'h0, 2, 2, 8'h7F);
        issue(3'b101, 16'h00F0, 16'h0000, 0, 2'b00, 0, 8'h00, 16'h0000, 0, 16'h0, 0, 16'h0, 1, 8'hF0, 1, 1, 8'hF0);
        issue(3'b010, 16'h0000, 16'h0000, 0, 2'b00, 0, 8'h00, 16'h0000, 0, 16'h0, 1, 16'h0000, 0, 8'h0, 2, 2, 8'hF1);
        issue(3'b101, 16'h0000, 16'h0000, 0, 2'b00, 0, 8'h00, 16'h0000, 0, 16'h0, 0, 16'h0, 1, 8'h00, 1, 1, 8'h00);
        issue(3'b001, 16'h5555, 16'h0000, 0, 2'b00, 1, 8'hFF, 16'h5555, 0, 16'h0, 0, 16'h0, 0, 8'h0, 2, 2, 8'hFF);
`endif

        // Reset during the DEC cycle of a PUSH must abandon the write
        we_seen  = 0;
        op_valid = 1'b1; op_code = 3'b001; op_data = 16'h9999;
        @(posedge clk);
        #1 op_valid = 1'b0; op_code = 3'b000;
        chk("dec_cycle_dcr", dcr_SP, 1'b1);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_op_ready", op_ready, 1'b1);
            chk("abort_done", done, 1'b0);
        end
        chk("abort_no_we", we_seen, 1'b0);

        issue(3'b001, 16'h7777, 16'h0000, 0, 2'b00, 1, 8'hEF, 16'h7777, 0, 16'h0, 0, 16'h0, 0, 8'h0, 2, 2, 8'hEF);
        chk("scoreboard_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
